// File: rtl/tdm_demux_1_to_n.sv
// tdm_demux_1_to_n: receive side of a 1-bit TDM link. Each valid slot bit is steered into
//   a shadow register, and the full channel word is published to ch_out once per good frame.
// Latency: ch_out/frame_done update 1 cycle after the edge that samples the last slot bit.
// Backpressure: none. Idle cycles (din_valid=0) freeze all state; full rate is supported.
//
// Optional build macro: TDM_DEMUX_PARITY_EN
//   Appends an even-parity slot after the N_CH data slots and adds the parity_err output.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   din        - serial bit for the current slot
//   din_valid  - din/frame_sync are meaningful this cycle
//   frame_sync - current valid bit is slot 0
//   ch_out     - registered channel word, bit i = slot i of the last good frame
//   frame_done - 1-cycle pulse, ch_out just updated
//   sync_err   - 1-cycle pulse, framing violation (lost sync or early sync)
//   busy       - FSM is in RUN
//   parity_err - (parity build only) 1-cycle pulse, parity slot mismatch

module tdm_demux_1_to_n #(
  parameter int N_CH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din,
  input  logic            din_valid,
  input  logic            frame_sync,
  output logic [N_CH-1:0] ch_out,
  output logic            frame_done,
  output logic            sync_err,
  output logic            busy
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  // The slot counter must reach the parity slot index N_CH in the parity build.
`ifdef TDM_DEMUX_PARITY_EN
  localparam int SLOT_W = $clog2(N_CH + 1);
`else
  localparam int SLOT_W = $clog2(N_CH);
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q,      state_d;
  logic [SLOT_W-1:0] slot_q,       slot_d;
  logic [N_CH-1:0]   shadow_q,     shadow_d;
  logic [N_CH-1:0]   ch_out_q,     ch_out_d;
  logic              frame_done_q, frame_done_d;
  logic              sync_err_q,   sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic              parity_err_q, parity_err_d;
`endif

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      shadow_q     <= '0;
      ch_out_q     <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      ch_out_q     <= ch_out_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    ch_out_d     = ch_out_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    parity_err_d = 1'b0;
`endif

    if (din_valid) begin
      unique case (state_q)
        IDLE: begin
          // Unsynchronised bits are silently dropped until a sync arrives.
          if (frame_sync) begin
            shadow_d[0] = din;
            slot_d      = SLOT_W'(1);
            state_d     = RUN;
          end
        end

        RUN: begin
          if (frame_sync) begin
            // Sync anywhere but slot 0 means the previous frame was short;
            // the partial frame is abandoned and this bit starts a new one.
            if (slot_q != '0) begin
              sync_err_d = 1'b1;
            end
            shadow_d[0] = din;
            slot_d      = SLOT_W'(1);
          end else if (slot_q == '0) begin
            // A frame boundary arrived without sync: alignment is lost.
            sync_err_d = 1'b1;
            state_d    = IDLE;
            slot_d     = '0;
          end else begin
`ifdef TDM_DEMUX_PARITY_EN
            if (slot_q == SLOT_W'(N_CH)) begin
              // Even parity: the parity bit equals the XOR of the data bits.
              if (din == ^shadow_q) begin
                ch_out_d     = shadow_q;
                frame_done_d = 1'b1;
              end else begin
                parity_err_d = 1'b1;
              end
              slot_d = '0;
            end else begin
              for (int i = 1; i < N_CH; i++) begin
                if (slot_q == SLOT_W'(i)) begin
                  shadow_d[i] = din;
                end
              end
              slot_d = slot_q + SLOT_W'(1);
            end
`else
            for (int i = 1; i < N_CH; i++) begin
              if (slot_q == SLOT_W'(i)) begin
                shadow_d[i] = din;
              end
            end
            // N_CH is a power of two, so the counter wraps to 0 after the last slot.
            slot_d = slot_q + SLOT_W'(1);
            if (slot_q == SLOT_W'(N_CH - 1)) begin
              // shadow_d already holds the last bit in the top position.
              ch_out_d     = shadow_d;
              frame_done_d = 1'b1;
            end
`endif
          end
        end

        default: begin
          state_d = IDLE;
          slot_d  = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ch_out     = ch_out_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign busy       = (state_q == RUN);
`ifdef TDM_DEMUX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux_1_to_n.sv
// tb_tdm_demux_1_to_n: directed bench for tdm_demux_1_to_n with N_CH=4.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: n/a.

module tb_tdm_demux_1_to_n;

  localparam int N_CH = 4;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_LEN = N_CH + 1;
`else
  localparam int FRAME_LEN = N_CH;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            din;
  logic            din_valid;
  logic            frame_sync;
  logic [N_CH-1:0] ch_out;
  logic            frame_done;
  logic            sync_err;
  logic            busy;
`ifdef TDM_DEMUX_PARITY_EN
  logic            parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fd_cnt   = 0;
  int se_cnt   = 0;
  int last_fd_cyc = 0;
  int prev_fd_cyc = 0;
  int f0;
  bit both_seen = 1'b0;
  logic par = 1'b0;

  tdm_demux_1_to_n #(.N_CH(N_CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch_out     (ch_out),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .busy       (busy)
`ifdef TDM_DEMUX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle; on return the outputs for that cycle are visible.
  task automatic step(input bit v, input bit s, input bit d);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(negedge clk);
    cyc++;
    if (frame_done === 1'b1) begin
      fd_cnt++;
      prev_fd_cyc = last_fd_cyc;
      last_fd_cyc = cyc;
    end
    if (sync_err === 1'b1) se_cnt++;
    if (frame_done === 1'b1 && sync_err === 1'b1) both_seen = 1'b1;
  endtask

  // Valid data bit; keeps a running XOR so the parity build can append its slot.
  task automatic dbit(input bit s, input bit d);
    if (s) par = d;
    else   par = par ^ d;
    step(1'b1, s, d);
  endtask

  task automatic par_slot();
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b1, 1'b0, par);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    @(negedge clk);

    // Reset wins over an active sync bit.
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("rst_ch_out",   ch_out,     0);
    check("rst_fd",       frame_done, 0);
    check("rst_se",       sync_err,   0);
    check("rst_busy",     busy,       0);
    rst = 1'b0;
    fd_cnt = 0; se_cnt = 0;

    // Single contiguous frame 1,0,1,1 -> 4'b1101.
    dbit(1'b1, 1'b1);
    check("f1_busy", busy, 1);
    dbit(1'b0, 1'b0);
    dbit(1'b0, 1'b1);
    check("f1_no_early_fd", fd_cnt, 0);
    dbit(1'b0, 1'b1);
    par_slot();
    check("f1_fd",     frame_done, 1);
    check("f1_ch_out", ch_out,     4'b1101);
    check("f1_busy2",  busy,       1);
    check("f1_no_se",  se_cnt,     0);

    // Same frame with idle gaps, starting from a clean reset.
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("gap_rst_ch_out", ch_out, 0);
    fd_cnt = 0;
    dbit(1'b1, 1'b1); idle(1);
    dbit(1'b0, 1'b0); idle(2);
    dbit(1'b0, 1'b1); idle(3);
    check("gap_no_early_fd", fd_cnt, 0);
    dbit(1'b0, 1'b1);
    par_slot();
    check("gap_fd",     frame_done, 1);
    check("gap_ch_out", ch_out,     4'b1101);
    idle(2);
    check("gap_fd_once", fd_cnt, 1);

    // Back-to-back frames at full rate.
    dbit(1'b1, 1'b1); dbit(1'b0, 1'b0); dbit(1'b0, 1'b1); dbit(1'b0, 1'b1); par_slot();
    check("b2b_fd1",     frame_done, 1);
    check("b2b_ch_out1", ch_out,     4'b1101);
    dbit(1'b1, 1'b0); dbit(1'b0, 1'b1); dbit(1'b0, 1'b1); dbit(1'b0, 1'b0); par_slot();
    check("b2b_fd2",     frame_done, 1);
    check("b2b_ch_out2", ch_out,     4'b0110);
    check("b2b_spacing", last_fd_cyc - prev_fd_cyc, FRAME_LEN);

    // Early sync: two bits, then a new frame 0,0,0,1 -> 4'b1000.
    f0 = fd_cnt;
    dbit(1'b1, 1'b1);
    dbit(1'b0, 1'b0);
    dbit(1'b1, 1'b0);
    check("es_se",     sync_err,   1);
    check("es_no_fd",  frame_done, 0);
    check("es_busy",   busy,       1);
    check("es_held",   ch_out,     4'b0110);
    dbit(1'b0, 1'b0); dbit(1'b0, 1'b0); dbit(1'b0, 1'b1); par_slot();
    check("es_fd",       frame_done, 1);
    check("es_ch_out",   ch_out,     4'b1000);
    check("es_fd_count", fd_cnt - f0, 1);

    // Lost sync at slot 0, then an unsynchronised bit in IDLE.
    step(1'b1, 1'b0, 1'b1);
    check("ls_se",     sync_err, 1);
    check("ls_busy",   busy,     0);
    check("ls_ch_out", ch_out,   4'b1000);
    step(1'b1, 1'b0, 1'b0);
    check("idle_drop_se",   sync_err, 0);
    check("idle_drop_busy", busy,     0);

    // Reset in the middle of a frame.
    f0 = fd_cnt;
    dbit(1'b1, 1'b1);
    dbit(1'b0, 1'b1);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    check("mr_ch_out", ch_out,     0);
    check("mr_busy",   busy,       0);
    check("mr_fd",     frame_done, 0);
    check("mr_se",     sync_err,   0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("mr_no_fd",    fd_cnt - f0, 0);
    check("mr_busy_end", busy,        0);
    check("mr_ch_out2",  ch_out,      0);

`ifdef TDM_DEMUX_PARITY_EN
    // Good parity publishes; bad parity holds ch_out and flags parity_err.
    dbit(1'b1, 1'b1); dbit(1'b0, 1'b0); dbit(1'b0, 1'b1); dbit(1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("par_ok_fd",     frame_done, 1);
    check("par_ok_ch_out", ch_out,     4'b1101);
    dbit(1'b1, 1'b1); dbit(1'b0, 1'b0); dbit(1'b0, 1'b1); dbit(1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("par_bad_pe",     parity_err, 1);
    check("par_bad_fd",     frame_done, 0);
    check("par_bad_ch_out", ch_out,     4'b1101);
    check("par_bad_busy",   busy,       1);
`endif

    check("fd_se_exclusive", both_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1_to_n.md
Name: tdm_demux_1_to_n

Overview:
- Sequential demultiplexer: receiving end of a 1-bit time-division-multiplexed link.
- A mux-based serializer drives one bit per slot; this block steers each slot's bit to its channel.
- Channel bits are collected in a shadow register and presented as a registered parallel word once per complete frame.
- Sits between the serial link and the downstream per-channel logic.

Parameters:
- N_CH, 4, number of channels (slots per frame); power of 2, >= 2.
- SLOT_W, $clog2(N_CH), width of slot counter; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit for current slot.
- din_valid  input  1  din carries a slot bit this cycle; idle cycles allowed anywhere.
- frame_sync  input  1  qualified by din_valid; marks current bit as slot 0.
- ch_out  output  N_CH  registered channel word; bit i = slot i of last good frame.
- frame_done  output  1  one-cycle pulse, ch_out just updated.
- sync_err  output  1  one-cycle pulse, framing violation detected.
- busy  output  1  high while FSM in RUN.

Behaviour:
- Interface is fixed: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at edge): state=IDLE, slot=0, shadow=0, ch_out=0, frame_done=0, sync_err=0, busy=0. Reset overrides all inputs, including mid-frame; the partial frame is discarded.
- Only cycles with din_valid=1 advance state. With din_valid=0, state/slot/shadow hold and pulse outputs are 0.
- FSM states: IDLE, RUN. busy=1 iff state==RUN (registered).
- IDLE, valid & sync=1: shadow[0]<=din, slot<=1, go RUN.
- IDLE, valid & sync=0: bit dropped, stay IDLE, no sync_err.
- RUN, valid & sync=0 & slot!=0: shadow[slot]<=din, slot<=slot+1.
- Last slot: when slot==N_CH-1, ch_out<={din,shadow[N_CH-2:0]}, frame_done<=1 next cycle, slot wraps to 0, stay RUN.
- RUN, slot==0, valid & sync=1: normal start of next frame; shadow[0]<=din, slot<=1.
- RUN, slot==0, valid & sync=0: lost sync. sync_err pulse, go IDLE, slot<=0, ch_out unchanged.
- RUN, slot!=0, valid & sync=1: early sync (short frame). sync_err pulse, partial frame discarded (ch_out unchanged), bit taken as new slot 0: shadow[0]<=din, slot<=1, stay RUN.
- Latency: ch_out and frame_done visible one cycle after the edge that samples the last slot bit.
- frame_done and sync_err are never high together.
- Back-to-back frames with zero idle cycles are supported at full rate (one frame per N_CH valid cycles).
- Slot counter is SLOT_W bits and wraps naturally at N_CH.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined: frame is N_CH+1 valid slots. Slot N_CH carries even parity over the N_CH data bits.
- Defined, parity match: ch_out update and frame_done behave as above, deferred to the parity slot.
- Defined, parity mismatch: ch_out holds, frame_done=0, extra output parity_err (1 bit, reset 0) pulses one cycle, FSM stays RUN at slot 0.
- Defined: slot counter widens to $clog2(N_CH+1). Early-sync rule applies to the parity slot too.
- Undefined: no parity slot, no parity_err port, behaviour as in Behaviour.

Test Plan:
- Reset then frame: (N_CH=4) rst 2 cycles; send sync+1,0,1,1 contiguous. Expect ch_out=4'b1101 and frame_done=1 one cycle after last bit, busy=1; sync_err stays 0.
- Idle gaps: same frame with din_valid=0 gaps of 1-3 cycles between bits. Expect identical ch_out=4'b1101; single frame_done only after 4th valid bit.
- Back-to-back: frames 1,0,1,1 then 0,1,1,0 with no gap. Expect ch_out=4'b1101 then 4'b0110, frame_done pulses exactly 4 cycles apart.
- Early sync: sync+1,0 then sync+0,0,0,1. Expect sync_err pulse on 3rd bit, no frame_done for the partial frame, then ch_out=4'b1000.
- Lost sync / mid-frame reset: complete frame, then valid bit with sync=0 at slot 0. Expect sync_err, busy=0, ch_out held. Separately, rst mid-frame: expect all outputs 0 next cycle and no frame_done.
- Parity (TDM_DEMUX_PARITY_EN): data 1,0,1,1 with parity 1 -> frame_done, ch_out=4'b1101. Same data with parity 0 -> parity_err, ch_out unchanged.
